// File: rtl/combine_ctrl_pkg.sv
// Shared types and helpers for the layer-combine sweep sequencer.
package combine_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int P_FRAC = 22;
   localparam int RES_W  = 3 + P_FRAC;

   typedef struct packed {
      logic signed [RES_W-1:0] enum_real;
      logic signed [RES_W-1:0] enum_imag;
      logic signed [RES_W-1:0] denum;
   } result_t;

   // One extra stage for the registered combine outputs after sin/cos.
   function automatic int pipe_lat(input int trig_lat);
      return trig_lat + 1;
   endfunction

endpackage

// File: rtl/combine_result_fifo.sv
// Synchronous result FIFO with flush; head is gated to zero while empty.
module combine_result_fifo #(
   parameter int W     = 75,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_flush,
   input  logic                         i_push,
   input  logic [W-1:0]                 i_data,
   input  logic                         i_pop,
   output logic [W-1:0]                 o_data,
   output logic                         o_valid,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   always_comb begin
      do_pop   = i_pop && (count_q != '0);
      do_push  = i_push && ((count_q != CW'(DEPTH)) || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !i_flush) mem_q[wr_ptr_q] <= i_data;
   end

   assign o_valid = (count_q != '0);
   assign o_data  = o_valid ? mem_q[rd_ptr_q] : '0;
   assign o_count = count_q;

endmodule

// File: rtl/combine_sweep_ctrl.sv
// Sweep sequencer: credit-limited index issue, latency tracker and result FIFO
// for the layer-combine datapath.
module combine_sweep_ctrl
   import combine_ctrl_pkg::*;
#(
   parameter int p        = P_FRAC,
   parameter int IDX_W    = 16,
   parameter int TRIG_LAT = 4,
   parameter int DEPTH    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [IDX_W-1:0] i_idx_first,
   input  logic [IDX_W-1:0] i_idx_step,
   input  logic [IDX_W-1:0] i_n_points,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_idx_valid,
   input  logic [p+2:0]     i_enum_real,
   input  logic [p+2:0]     i_enum_imag,
   input  logic [p+2:0]     i_denum,
   output logic [p+2:0]     o_enum_real,
   output logic [p+2:0]     o_enum_imag,
   output logic [p+2:0]     o_denum,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_busy,
   output logic             o_done
);
   localparam int PIPE_LAT = pipe_lat(TRIG_LAT);
   localparam int RW       = 3 + p;
   localparam int CW       = $clog2(DEPTH + 1);
   localparam int FW       = $clog2(PIPE_LAT + 1);

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d, step_q, step_d, n_q, n_d, issued_q, issued_d;
   logic [PIPE_LAT-1:0]  pipe_q, pipe_d;
   logic [FW-1:0]        in_flight;
   logic [CW-1:0]        fifo_count;
   logic                 fifo_valid, fifo_pop, issue, last_issue, abort_act, credit_ok;
   logic [3*RW-1:0]      fifo_rdata;

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < PIPE_LAT; i++) in_flight = in_flight + FW'(pipe_q[i]);
   end

   // Every issued point already owns a FIFO slot, so the FIFO can never overflow.
   assign credit_ok  = (int'(in_flight) + int'(fifo_count)) < DEPTH;
   assign abort_act  = i_abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
   assign issue      = (state_q == ST_RUN) && !i_abort && (issued_q < n_q) && credit_ok;
   assign last_issue = issue && (issued_q == (n_q - IDX_W'(1)));
   assign fifo_pop   = fifo_valid && i_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (i_start) state_d = (i_n_points == '0) ? ST_DONE : ST_RUN;
         ST_RUN:   if (abort_act) state_d = ST_IDLE;
                   else if (last_issue) state_d = ST_DRAIN;
         // Leave on the last pop so o_done lands the cycle after it.
         ST_DRAIN: if (abort_act) state_d = ST_IDLE;
                   else if ((in_flight == '0) &&
                            ((fifo_count == '0) || ((fifo_count == CW'(1)) && fifo_pop)))
                      state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_busy      = (state_q != ST_IDLE);
      o_done      = (state_q == ST_DONE);
      o_idx_valid = issue;
      o_idx       = idx_q;
   end

   always_comb begin
      idx_d    = idx_q;
      step_d   = step_q;
      n_d      = n_q;
      issued_d = issued_q;
      pipe_d   = {pipe_q[PIPE_LAT-2:0], issue};
      if ((state_q == ST_IDLE) && i_start) begin
         idx_d    = i_idx_first;
         step_d   = i_idx_step;
         n_d      = i_n_points;
         issued_d = '0;
      end
      if (issue) begin
         idx_d    = idx_q + step_q;
         issued_d = issued_q + IDX_W'(1);
      end
      if (abort_act) begin
         pipe_d   = '0;
         issued_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q    <= '0;
         step_q   <= '0;
         n_q      <= '0;
         issued_q <= '0;
         pipe_q   <= '0;
      end else begin
         idx_q    <= idx_d;
         step_q   <= step_d;
         n_q      <= n_d;
         issued_q <= issued_d;
         pipe_q   <= pipe_d;
      end
   end

   combine_result_fifo #(
      .W     (3 * RW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (abort_act),
      .i_push  (pipe_q[PIPE_LAT-1]),
      .i_data  ({i_enum_real, i_enum_imag, i_denum}),
      .i_pop   (fifo_pop),
      .o_data  (fifo_rdata),
      .o_valid (fifo_valid),
      .o_count (fifo_count)
   );

   assign o_valid = fifo_valid;
   assign {o_enum_real, o_enum_imag, o_denum} = fifo_rdata;

endmodule

// File: tb/tb_combine_sweep_ctrl.sv
// Bench for combine_sweep_ctrl: upstream combine model, index model and result scoreboard.
module tb_combine_sweep_ctrl;
   localparam int IDX_W    = 16;
   localparam int RW       = 25;
   localparam int TRIG_LAT = 4;
   localparam int PIPE_LAT = TRIG_LAT + 1;
   localparam int DEPTH    = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             i_start = 1'b0, i_abort = 1'b0, i_ready = 1'b0;
   logic [IDX_W-1:0] i_idx_first = '0, i_idx_step = '0, i_n_points = '0;
   logic [IDX_W-1:0] o_idx;
   logic             o_idx_valid, o_valid, o_busy, o_done;
   logic [RW-1:0]    i_enum_real = '0, i_enum_imag = '0, i_denum = '0;
   logic [RW-1:0]    o_enum_real, o_enum_imag, o_denum;

   combine_sweep_ctrl #(.p(22), .IDX_W(IDX_W), .TRIG_LAT(TRIG_LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
      .i_idx_first(i_idx_first), .i_idx_step(i_idx_step), .i_n_points(i_n_points),
      .o_idx(o_idx), .o_idx_valid(o_idx_valid),
      .i_enum_real(i_enum_real), .i_enum_imag(i_enum_imag), .i_denum(i_denum),
      .o_enum_real(o_enum_real), .o_enum_imag(o_enum_imag), .o_denum(o_denum),
      .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the sin/cos + combine stages: a recognisable word per index.
   function automatic logic [3*RW-1:0] exp_res(input logic [IDX_W-1:0] idx);
      logic [IDX_W-1:0] nidx;
      nidx = ~idx;
      return {9'h155, idx, 9'h0AA, nidx, idx[8:0], idx};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else
         $display("ok   %s: %0h", name, act);
   endtask

   task automatic fail_now(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s: %s", name, what);
   endtask

   typedef struct { logic v; logic [IDX_W-1:0] idx; } hist_t;
   hist_t            hist [PIPE_LAT+1];
   logic [3*RW-1:0]  sb_q [$];
   logic [3*RW-1:0]  sb_exp;
   logic [IDX_W-1:0] m_idx = '0, m_step = '0, m_left = '0;
   int issued_total = 0, pop_total = 0, done_total = 0;
   int start_cyc = 0, first_issue_cyc = -1, first_valid_cyc = -1, last_pop_cyc = 0, done_cyc = 0;
   logic             clr;

   always @(negedge clk) begin
      clr = 1'b0;
      if (!rst_n) begin
         sb_q.delete();
         m_left = '0;
         clr = 1'b1;
      end else begin
         if (o_valid && i_ready) begin
            if (sb_q.size() == 0) fail_now("pop", "result popped with empty scoreboard");
            else begin
               sb_exp = sb_q.pop_front();
               chk($sformatf("result#%0d", pop_total), {o_enum_real, o_enum_imag, o_denum}, sb_exp);
            end
            pop_total++;
            last_pop_cyc = cyc;
         end
         if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (o_done) begin
            done_total++;
            done_cyc = cyc;
         end
         if (o_idx_valid) begin
            if (m_left == '0) fail_now("issue", $sformatf("unexpected issue of idx %0h", o_idx));
            else begin
               chk($sformatf("o_idx#%0d", issued_total), o_idx, m_idx);
               m_idx  = m_idx + m_step;
               m_left = m_left - 1'b1;
               sb_q.push_back(exp_res(o_idx));
            end
            issued_total++;
            if (first_issue_cyc < 0) first_issue_cyc = cyc;
         end
         if (i_start && !o_busy) begin
            m_idx = i_idx_first;
            m_step = i_idx_step;
            m_left = i_n_points;
            start_cyc = cyc;
            first_issue_cyc = -1;
            first_valid_cyc = -1;
         end
         if (i_abort && o_busy && !o_done) begin
            sb_q.delete();
            m_left = '0;
            clr = 1'b1;
         end
      end
      for (int k = PIPE_LAT; k > 0; k--) hist[k] = hist[k-1];
      hist[0].v   = rst_n && o_idx_valid;
      hist[0].idx = o_idx;
      if (clr) for (int k = 0; k <= PIPE_LAT; k++) hist[k].v = 1'b0;
      if (hist[PIPE_LAT].v === 1'b1)
         {i_enum_real, i_enum_imag, i_denum} = exp_res(hist[PIPE_LAT].idx);
      else
         {i_enum_real, i_enum_imag, i_denum} = 75'({$urandom(), $urandom(), $urandom()});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_o_idx"}, o_idx, 0);
      chk({tag, "_o_idx_valid"}, o_idx_valid, 0);
      chk({tag, "_o_valid"}, o_valid, 0);
      chk({tag, "_o_enum_real"}, o_enum_real, 0);
      chk({tag, "_o_enum_imag"}, o_enum_imag, 0);
      chk({tag, "_o_denum"}, o_denum, 0);
      chk({tag, "_o_busy"}, o_busy, 0);
      chk({tag, "_o_done"}, o_done, 0);
   endtask

   typedef struct {
      string            name;
      logic [IDX_W-1:0] first, step, n;
      int               stall;
      int               stall_issued;
   } vec_t;

   task automatic run_sweep(input vec_t v);
      int  done0, iss0, pop0;
      bit  got;
      done0 = done_total; iss0 = issued_total; pop0 = pop_total;
      i_idx_first = v.first; i_idx_step = v.step; i_n_points = v.n;
      i_ready = (v.stall == 0);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      if (v.stall > 0) begin
         repeat (v.stall) tick();
         chk({v.name, "_stall_issued"}, issued_total - iss0, v.stall_issued);
         chk({v.name, "_stall_pops"}, pop_total - pop0, 0);
         i_ready = 1'b1;
      end
      got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
         tick();
         if (done_total != done0) got = 1'b1;
      end
      if (!got) fail_now({v.name, "_done"}, "o_done not seen within 400 cycles");
      repeat (3) tick();
      chk({v.name, "_done_pulses"}, done_total - done0, 1);
      chk({v.name, "_issued"}, issued_total - iss0, v.n);
      chk({v.name, "_delivered"}, pop_total - pop0, v.n);
      chk({v.name, "_sb_left"}, sb_q.size(), 0);
      if (v.n == 0) begin
         chk({v.name, "_done_lat"}, done_cyc - start_cyc, 1);
         chk({v.name, "_no_valid"}, first_valid_cyc, -1);
      end else begin
         chk({v.name, "_issue_lat"}, first_issue_cyc - start_cyc, 1);
         chk({v.name, "_done_after_pop"}, done_cyc - last_pop_cyc, 1);
         if (v.stall == 0)
            chk({v.name, "_valid_lat"}, first_valid_cyc - start_cyc, 1 + PIPE_LAT + 1);
      end
   endtask

   vec_t vecs [5];

   initial begin
      int iss0, done0, c;
      vecs[0] = '{name: "basic",  first: 16'd10,   step: 16'd3,    n: 16'd5,  stall: 0,  stall_issued: 0};
      vecs[1] = '{name: "bpress", first: 16'd100,  step: 16'd7,    n: 16'd20, stall: 30, stall_issued: DEPTH};
      vecs[2] = '{name: "wrap",   first: 16'hFFFE, step: 16'd1,    n: 16'd4,  stall: 0,  stall_issued: 0};
      vecs[3] = '{name: "zero",   first: 16'd5,    step: 16'd1,    n: 16'd0,  stall: 0,  stall_issued: 0};
      vecs[4] = '{name: "down",   first: 16'd3,    step: 16'hFFFF, n: 16'd12, stall: 20, stall_issued: DEPTH};

      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) run_sweep(vecs[i]);

      // Abort after three issues, then restart straight away.
      iss0 = issued_total; done0 = done_total;
      i_ready = 1'b1;
      i_idx_first = 16'd50; i_idx_step = 16'd2; i_n_points = 16'd20;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      c = 0;
      while ((issued_total - iss0) < 3 && c < 20) begin
         tick();
         c++;
      end
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      chk("abort_issued", issued_total - iss0, 3);
      chk("abort_busy", o_busy, 0);
      chk("abort_o_valid", o_valid, 0);
      chk("abort_o_done", o_done, 0);
      chk("abort_done_pulses", done_total - done0, 0);
      run_sweep('{name: "restart", first: 16'd7, step: 16'd5, n: 16'd6, stall: 0, stall_issued: 0});

      // Reset while draining with two results parked in the FIFO.
      i_ready = 1'b0;
      i_idx_first = 16'd300; i_idx_step = 16'd1; i_n_points = 16'd2;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      repeat (10) tick();
      chk("drain_busy", o_busy, 1);
      chk("drain_o_valid", o_valid, 1);
      chk("drain_head", {o_enum_real, o_enum_imag, o_denum}, exp_res(16'd300));
      rst_n = 1'b0;
      tick();
      check_reset_outputs("midreset");
      rst_n = 1'b1;
      i_ready = 1'b1;
      repeat (3) tick();
      chk("post_reset_o_valid", o_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/combine_sweep_ctrl.md
# combine_sweep_ctrl

Sequencer for the layer-combine datapath: it sweeps a frequency index range, issues one index per cycle to the upstream sin/cos stage feeding the combine block, and tracks each issued point through the fixed pipeline latency. It captures the three combine results (enum real, enum imag, denum) into a result FIFO and presents them downstream on a valid/ready handshake. Credit-based issue guarantees no result is ever dropped under backpressure. It sits between the sweep configuration registers and the divider/magnitude stage.

## Interface
- p, 22, fractional bits of the 3Qp result words
- IDX_W, 16, frequency index width
- TRIG_LAT, 4, cycles from issued index to valid sin/cos at the combine inputs
- DEPTH, 8, result FIFO depth (power of two, ≥ TRIG_LAT+2)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- i_start  in  1  start pulse, accepted only in IDLE
- i_abort  in  1  abort current sweep
- i_idx_first  in  IDX_W  first frequency index
- i_idx_step  in  IDX_W  index increment (unsigned, wraps mod 2^IDX_W)
- i_n_points  in  IDX_W  points in sweep; 0 means no points
- o_idx  out  IDX_W  index to sin/cos stage
- o_idx_valid  out  1  o_idx is an issued point this cycle
- i_enum_real, i_enum_imag, i_denum  in  3+p each  registered combine outputs
- o_enum_real, o_enum_imag, o_denum  out  3+p each  FIFO head
- o_valid  out  1  FIFO head valid
- i_ready  in  1  downstream accepts head
- o_busy  out  1  state ≠ IDLE
- o_done  out  1  one-cycle pulse at sweep completion

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: i_start latches config, clears counters → RUN; if i_n_points==0 → DONE directly.
- RUN: issue when issued_cnt < n_points and credit = in_flight + fifo_count < DEPTH; on issue o_idx_valid=1, o_idx=current index, index += step, issued_cnt++. Last issue → DRAIN.
- DRAIN: no issue; wait in_flight==0, fifo_count==0 → DONE.
- DONE: o_done=1 for one cycle → IDLE.
- Pipeline tracker: shift register of length PIPE_LAT=TRIG_LAT+1 carries issue bits; its output is the FIFO write enable, sampling i_enum_real/imag/i_denum that cycle. in_flight = popcount (or up/down counter).
- FIFO pop on o_valid && i_ready. Simultaneous push and pop at full is legal (credit permits it); count unchanged.
- i_abort in RUN/DRAIN: clear tracker, FIFO, counters; → IDLE next cycle, no o_done. i_abort in IDLE/DONE: ignored; i_start outside IDLE: ignored. Abort and start same cycle in IDLE: start wins.
- Data is passed through unmodified; no arithmetic on result words.

## Timing
- Reset: state IDLE; o_idx=0, o_idx_valid=0, o_valid=0, result outputs 0, o_busy=0, o_done=0; FIFO and tracker empty.
- i_start at cycle t → first o_idx_valid at t+1.
- Issue at cycle u → FIFO write at u+PIPE_LAT → o_valid at u+PIPE_LAT+1 (registered FIFO head).
- Throughput with i_ready held high: one point per cycle, no bubbles.
- o_done asserted the cycle after the last pop.
- Reset mid-sweep has same effect as abort plus returning all outputs to reset values.

## Structure
- Package combine_ctrl_pkg: state enum, PIPE_LAT derivation, result-word struct (three 3+p signed fields).
- Sub-module combine_result_fifo: synchronous FIFO, DEPTH×3(3+p) bits, registered head, count output, flush input.

## Test plan
- Basic: first=10, step=3, n=5, i_ready=1 → o_idx 10,13,16,19,22 on consecutive cycles; five results in order, o_valid first at start+1+PIPE_LAT+1, o_done once.
- Backpressure: n=20, i_ready=0 for 30 cycles → issue stalls after DEPTH in_flight+stored, no result lost; release → all 20 delivered in order.
- Wrap: first=0xFFFE, step=1, n=4 → o_idx FFFE,FFFF,0000,0001.
- Zero points: n=0 → o_done one cycle after start, no o_idx_valid, no o_valid.
- Abort mid-RUN after 3 issues → IDLE next cycle, o_valid=0, no o_done; immediate new start runs cleanly.
- Reset asserted in DRAIN with FIFO holding 2 entries → all outputs at reset values next cycle, o_valid=0.
